// File: rtl/axis_reg_pipeline_pkg.sv
// ============================================================================
// Module   : axis_reg_pipeline_pkg
// Brief    : Mode encodings, skid-stage state type and sizing helper for the
//            AXI-Stream register pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_reg_pipeline_pkg;

    localparam int AXIS_REG_FULL = 0;
    localparam int AXIS_REG_FWD  = 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Occupancy counter width; a bypass pipeline still exposes a 1-bit port.
    function automatic int occ_width(input int stages);
        return (stages < 1) ? 1 : $clog2(2 * stages + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_stage.sv
// ============================================================================
// Module   : axis_skid_stage
// Brief    : One AXI-Stream register slice: FULL (main+skid, registered ready)
//            or FWD (single register, combinational ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_stage
    import axis_reg_pipeline_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int MODE  = 0,
    localparam int KEEP_W = WIDTH / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    output logic [1:0]        count
);

    localparam int PAYLOAD_W = WIDTH + KEEP_W + 1;

    logic [PAYLOAD_W-1:0] s_payload;
    logic [PAYLOAD_W-1:0] main_q;

    assign s_payload = {s_last, s_keep, s_data};
    assign {m_last, m_keep, m_data} = main_q;

    if (MODE == AXIS_REG_FWD) begin : g_fwd
        logic valid_q;
        logic ready_en_q;
        logic accept;

        // ready_en_q holds ready low through reset and for the release edge.
        assign s_ready = ready_en_q && (!valid_q || m_ready);
        assign accept  = s_valid && s_ready;
        assign m_valid = valid_q;
        assign count   = {1'b0, valid_q};

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                valid_q    <= 1'b0;
                ready_en_q <= 1'b0;
            end else begin
                ready_en_q <= 1'b1;
                if (accept) begin
                    valid_q <= 1'b1;
                end else if (m_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end

        always_ff @(posedge aclk) begin
            if (accept) begin
                main_q <= s_payload;
            end
        end
    end else begin : g_full
        skid_state_e          state_q;
        skid_state_e          state_d;
        logic                 ready_q;
        logic                 accept;
        logic                 take;
        logic                 load_main;
        logic                 load_skid;
        logic                 main_from_skid;
        logic [PAYLOAD_W-1:0] skid_q;

        assign accept  = s_valid && ready_q;
        assign take    = (state_q != SKID_EMPTY) && m_ready;
        assign s_ready = ready_q;
        assign m_valid = (state_q != SKID_EMPTY);
        assign count   = {state_q == SKID_TWO, state_q == SKID_ONE};

        always_comb begin
            state_d        = state_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d   = SKID_ONE;
                        load_main = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && take) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = SKID_TWO;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_d   = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (take) begin
                        state_d        = SKID_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end

        // Ready is a flop looking one state ahead, so m_ready never reaches s_ready.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                state_q <= SKID_EMPTY;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != SKID_TWO);
            end
        end

        always_ff @(posedge aclk) begin
            if (load_main) begin
                main_q <= s_payload;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_payload;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_reg_pipeline.sv
// ============================================================================
// Module   : axis_reg_pipeline
// Brief    : Cascade of STAGES AXI-Stream register slices with a beat
//            occupancy count; STAGES=0 is a plain wire-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_pipeline
    import axis_reg_pipeline_pkg::*;
#(
    parameter int WIDTH  = 512,
    parameter int STAGES = 1,
    parameter int MODE   = 0,
    localparam int KEEP_W = WIDTH / 8,
    localparam int OCC_W  = occ_width(STAGES)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [OCC_W-1:0]  occupancy
);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 1024) begin : g_bad_width
        $error("axis_reg_pipeline: WIDTH=%0d must be a multiple of 8 in 8..1024", WIDTH);
    end
    if (STAGES < 0 || STAGES > 8) begin : g_bad_stages
        $error("axis_reg_pipeline: STAGES=%0d must be in 0..8", STAGES);
    end
    if (MODE != AXIS_REG_FULL && MODE != AXIS_REG_FWD) begin : g_bad_mode
        $error("axis_reg_pipeline: MODE=%0d must be 0 (FULL) or 1 (FWD)", MODE);
    end

    if (STAGES == 0) begin : g_bypass
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign m_axis_tdata  = s_axis_tdata;
        assign m_axis_tkeep  = s_axis_tkeep;
        assign m_axis_tlast  = s_axis_tlast;
        assign occupancy     = '0;
    end else begin : g_chain
        logic [STAGES:0]   vld;
        logic [STAGES:0]   rdy;
        logic [STAGES:0]   lst;
        logic [WIDTH-1:0]  dat     [STAGES+1];
        logic [KEEP_W-1:0] kep     [STAGES+1];
        logic [OCC_W-1:0]  occ_acc [STAGES+1];

        assign vld[0]        = s_axis_tvalid;
        assign s_axis_tready = rdy[0];
        assign dat[0]        = s_axis_tdata;
        assign kep[0]        = s_axis_tkeep;
        assign lst[0]        = s_axis_tlast;
        assign occ_acc[0]    = '0;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic [1:0] cnt;

            axis_skid_stage #(
                .WIDTH (WIDTH),
                .MODE  (MODE)
            ) u_stage (
                .aclk    (aclk),
                .aresetn (aresetn),
                .s_valid (vld[i]),
                .s_ready (rdy[i]),
                .s_data  (dat[i]),
                .s_keep  (kep[i]),
                .s_last  (lst[i]),
                .m_valid (vld[i+1]),
                .m_ready (rdy[i+1]),
                .m_data  (dat[i+1]),
                .m_keep  (kep[i+1]),
                .m_last  (lst[i+1]),
                .count   (cnt)
            );

            assign occ_acc[i+1] = occ_acc[i] + OCC_W'(cnt);
        end

        assign m_axis_tvalid = vld[STAGES];
        assign rdy[STAGES]   = m_axis_tready;
        assign m_axis_tdata  = dat[STAGES];
        assign m_axis_tkeep  = kep[STAGES];
        assign m_axis_tlast  = lst[STAGES];
        assign occupancy     = occ_acc[STAGES];
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_reg_pipeline.sv
// ============================================================================
// Module   : tb_axis_reg_pipeline
// Brief    : Scoreboard bench for axis_reg_pipeline in FULL, FWD and bypass
//            configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_reg_pipeline;

    localparam int FW = 256;
    localparam int FK = FW / 8;
    localparam int WW = 64;
    localparam int WK = WW / 8;
    localparam int N_RAND = 2000;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    // FULL pipeline, 2 stages (the bypass instance shares its inputs)
    logic          f_s_valid, f_s_ready, f_s_last;
    logic [FW-1:0] f_s_data;
    logic [FK-1:0] f_s_keep;
    logic          f_m_valid, f_m_ready, f_m_last;
    logic [FW-1:0] f_m_data;
    logic [FK-1:0] f_m_keep;
    logic [2:0]    f_occ;

    logic          z_s_ready, z_m_valid, z_m_last;
    logic [FW-1:0] z_m_data;
    logic [FK-1:0] z_m_keep;
    logic [0:0]    z_occ;

    // FWD pipeline, 1 stage
    logic          w_s_valid, w_s_ready, w_s_last;
    logic [WW-1:0] w_s_data;
    logic [WK-1:0] w_s_keep;
    logic          w_m_valid, w_m_ready, w_m_last;
    logic [WW-1:0] w_m_data;
    logic [WK-1:0] w_m_keep;
    logic [1:0]    w_occ;

    axis_reg_pipeline #(.WIDTH(FW), .STAGES(2), .MODE(0)) u_full (
        .aclk(clk), .aresetn(aresetn),
        .s_axis_tvalid(f_s_valid), .s_axis_tready(f_s_ready), .s_axis_tdata(f_s_data),
        .s_axis_tkeep(f_s_keep), .s_axis_tlast(f_s_last),
        .m_axis_tvalid(f_m_valid), .m_axis_tready(f_m_ready), .m_axis_tdata(f_m_data),
        .m_axis_tkeep(f_m_keep), .m_axis_tlast(f_m_last), .occupancy(f_occ)
    );

    axis_reg_pipeline #(.WIDTH(FW), .STAGES(0), .MODE(0)) u_zero (
        .aclk(clk), .aresetn(aresetn),
        .s_axis_tvalid(f_s_valid), .s_axis_tready(z_s_ready), .s_axis_tdata(f_s_data),
        .s_axis_tkeep(f_s_keep), .s_axis_tlast(f_s_last),
        .m_axis_tvalid(z_m_valid), .m_axis_tready(f_m_ready), .m_axis_tdata(z_m_data),
        .m_axis_tkeep(z_m_keep), .m_axis_tlast(z_m_last), .occupancy(z_occ)
    );

    axis_reg_pipeline #(.WIDTH(WW), .STAGES(1), .MODE(1)) u_fwd (
        .aclk(clk), .aresetn(aresetn),
        .s_axis_tvalid(w_s_valid), .s_axis_tready(w_s_ready), .s_axis_tdata(w_s_data),
        .s_axis_tkeep(w_s_keep), .s_axis_tlast(w_s_last),
        .m_axis_tvalid(w_m_valid), .m_axis_tready(w_m_ready), .m_axis_tdata(w_m_data),
        .m_axis_tkeep(w_m_keep), .m_axis_tlast(w_m_last), .occupancy(w_occ)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [FW+FK:0] f_in_beat, f_out_beat, f_prev;
    logic [WW+WK:0] w_in_beat, w_out_beat, w_prev;
    assign f_in_beat  = {f_s_last, f_s_keep, f_s_data};
    assign f_out_beat = {f_m_last, f_m_keep, f_m_data};
    assign w_in_beat  = {w_s_last, w_s_keep, w_s_data};
    assign w_out_beat = {w_m_last, w_m_keep, w_m_data};

    logic [FW+FK:0] fq[$];
    logic [WW+WK:0] wq[$];
    int  f_acc = 0, f_taken = 0, w_acc = 0, w_taken = 0;
    bit  f_stall = 0, w_stall = 0;

    // Scoreboard monitors sample mid-cycle, where handshakes are settled.
    always @(negedge clk) begin : p_fmon
        check_eq("z_fwd", {z_m_valid, z_m_last, z_m_keep, z_m_data},
                          {f_s_valid, f_s_last, f_s_keep, f_s_data});
        check_eq("z_rdy", z_s_ready, f_m_ready);
        check_eq("z_occ", z_occ, 0);
        if (!aresetn) begin
            fq.delete();
            f_stall = 0;
        end else begin
            check_eq("f_occ", f_occ, fq.size());
            if (f_stall) begin
                check_eq("f_hold_valid", f_m_valid, 1);
                check_eq("f_hold_beat", f_out_beat, f_prev);
            end
            if (f_m_valid && f_m_ready) begin
                if (fq.size() == 0) begin
                    check_eq("f_extra_beat", 1, 0);
                end else begin
                    check_eq("f_beat", f_out_beat, fq.pop_front());
                end
                f_taken++;
            end
            if (f_s_valid && f_s_ready) fq.push_back(f_in_beat);
            f_stall = f_m_valid && !f_m_ready;
            f_prev  = f_out_beat;
        end
    end

    always @(negedge clk) begin : p_wmon
        if (!aresetn) begin
            wq.delete();
            w_stall = 0;
        end else begin
            check_eq("w_occ", w_occ, wq.size());
            if (w_stall) begin
                check_eq("w_hold_valid", w_m_valid, 1);
                check_eq("w_hold_beat", w_out_beat, w_prev);
            end
            if (w_m_valid && w_m_ready) begin
                if (wq.size() == 0) begin
                    check_eq("w_extra_beat", 1, 0);
                end else begin
                    check_eq("w_beat", w_out_beat, wq.pop_front());
                end
                w_taken++;
            end
            if (w_s_valid && w_s_ready) wq.push_back(w_in_beat);
            w_stall = w_m_valid && !w_m_ready;
            w_prev  = w_out_beat;
        end
    end

    task automatic f_randomize();
        for (int k = 0; k < FW / 32; k++) f_s_data[k*32 +: 32] = $urandom;
        f_s_keep = $urandom;
        f_s_last = 1'($urandom_range(1));
    endtask

    task automatic w_randomize();
        w_s_data = {$urandom, $urandom};
        w_s_keep = 8'($urandom);
        w_s_last = 1'($urandom_range(1));
    endtask

    // One cycle, entered just after a rising edge; a pending beat stays valid.
    task automatic f_cycle(input bit offer, input bit rdy);
        bit acc;
        if (!f_s_valid && offer) begin
            f_randomize();
            f_s_valid = 1'b1;
        end
        f_m_ready = rdy;
        @(negedge clk);
        acc = f_s_valid && f_s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            f_acc++;
            f_s_valid = 1'b0;
        end
    endtask

    task automatic w_cycle(input bit offer, input bit rdy);
        bit acc;
        if (!w_s_valid && offer) begin
            w_randomize();
            w_s_valid = 1'b1;
        end
        w_m_ready = rdy;
        @(negedge clk);
        acc = w_s_valid && w_s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            w_acc++;
            w_s_valid = 1'b0;
        end
    endtask

    initial begin : p_watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        logic [FW+FK:0] lat_exp;
        int t0;

        // Reset held with valid asserted upstream
        aresetn   = 1'b0;
        f_s_valid = 1'b1;
        w_s_valid = 1'b1;
        f_m_ready = 1'b0;
        w_m_ready = 1'b0;
        f_randomize();
        w_randomize();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_f_mvalid", f_m_valid, 0);
        check_eq("rst_f_occ", f_occ, 0);
        check_eq("rst_f_sready", f_s_ready, 0);
        check_eq("rst_w_mvalid", w_m_valid, 0);
        check_eq("rst_w_occ", w_occ, 0);
        check_eq("rst_w_sready", w_s_ready, 0);
        @(posedge clk);
        #1;
        aresetn   = 1'b1;
        f_s_valid = 1'b0;
        w_s_valid = 1'b0;
        @(negedge clk);
        check_eq("rel_f_sready_pre", f_s_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_f_sready", f_s_ready, 1);
        check_eq("rel_w_sready", w_s_ready, 1);

        // Latency of a single beat through an empty 2-stage pipeline
        @(posedge clk);
        #1;
        lat_exp   = {1'b1, {FK{1'b1}}, {(FW/8){8'hA5}}};
        f_s_data  = {(FW/8){8'hA5}};
        f_s_keep  = '1;
        f_s_last  = 1'b1;
        f_s_valid = 1'b1;
        f_m_ready = 1'b1;
        @(negedge clk);
        check_eq("lat_sready", f_s_ready, 1);
        @(posedge clk);
        #1;
        f_s_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_cycle1_mvalid", f_m_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("lat_cycle2_mvalid", f_m_valid, 1);
        check_eq("lat_beat", f_out_beat, lat_exp);
        @(posedge clk);
        #1;

        // Full throughput with downstream always ready
        t0    = f_taken;
        f_acc = 0;
        repeat (8) f_cycle(1'b1, 1'b1);
        check_eq("f_tput_in", f_acc, 8);
        repeat (4) f_cycle(1'b0, 1'b1);
        check_eq("f_tput_out", f_taken - t0, 8);

        // Back-pressure: 10 beats into a stalled 2-stage pipeline
        f_acc = 0;
        repeat (12) f_cycle((f_acc + int'(f_s_valid)) < 10, 1'b0);
        check_eq("bp_accepted", f_acc, 4);
        check_eq("bp_occ", f_occ, 4);
        check_eq("bp_sready", f_s_ready, 0);
        #1 f_m_ready = 1'b1;
        #1 check_eq("bp_no_comb_path", f_s_ready, 0);
        f_m_ready = 1'b0;
        t0 = f_taken;
        for (int i = 0; i < 100 && !(f_acc == 10 && !f_s_valid && fq.size() == 0); i++)
            f_cycle((f_acc + int'(f_s_valid)) < 10, 1'b1);
        check_eq("bp_total_in", f_acc, 10);
        check_eq("bp_total_out", f_taken - t0, 10);

        // Random valid/ready traffic
        t0    = f_taken;
        f_acc = 0;
        for (int i = 0; i < 40000 && (f_acc < N_RAND || fq.size() != 0); i++)
            f_cycle(((f_acc + int'(f_s_valid)) < N_RAND) && ($urandom_range(1) == 1),
                    $urandom_range(1) == 1);
        check_eq("rnd_in", f_acc, N_RAND);
        check_eq("rnd_out", f_taken - t0, N_RAND);

        // Reset in the middle of a 6-beat packet with 3 beats held
        f_acc = 0;
        for (int i = 0; i < 20 && f_acc < 3; i++) f_cycle(1'b1, 1'b0);
        if (!f_s_valid) begin
            f_randomize();
            f_s_valid = 1'b1;
        end
        check_eq("mr_occ_before", f_occ, 3);
        aresetn = 1'b0;
        #1;
        check_eq("mr_mvalid", f_m_valid, 0);
        check_eq("mr_occ", f_occ, 0);
        check_eq("mr_sready", f_s_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        f_s_valid = 1'b0;
        aresetn   = 1'b1;
        @(posedge clk);
        #1;
        t0    = f_taken;
        f_acc = 0;
        for (int i = 0; i < 50 && !(f_acc == 2 && !f_s_valid && fq.size() == 0); i++)
            f_cycle((f_acc + int'(f_s_valid)) < 2, 1'b1);
        check_eq("mr_new_in", f_acc, 2);
        check_eq("mr_new_out", f_taken - t0, 2);

        // FWD mode: streaming, then same-cycle ready drop once full
        w_acc = 0;
        repeat (8) w_cycle(1'b1, 1'b1);
        check_eq("fwd_tput_in", w_acc, 8);
        check_eq("fwd_full", w_m_valid, 1);
        w_m_ready = 1'b1;
        #1 check_eq("fwd_sready_hi", w_s_ready, 1);
        w_m_ready = 1'b0;
        #1 check_eq("fwd_sready_drop", w_s_ready, 0);
        for (int i = 0; i < 20 && wq.size() != 0; i++) w_cycle(1'b0, 1'b1);
        check_eq("fwd_tput_out", w_taken, 8);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
